// File: rtl/decoder_pkg.sv
// decoder_pkg: parameter limits and the elaboration-time width check that
// decoder_pipe and dec_onehot share.
// The DECODER_PKG_CHECK macro expands to a generate-if that stops elaboration
// when NUM_OUT does not fit in SEL_W select bits.

`ifndef DECODER_PKG_SV
`define DECODER_PKG_SV

package decoder_pkg;

  // Supported range of the select width.
  localparam int SEL_W_MIN = 1;
  localparam int SEL_W_MAX = 6;

  // Returns 1 when the select width is supported and the output count fits
  // in it (1 <= num_out <= 2**sel_w).
  function automatic bit onehot_width_ok(input int sel_w, input int num_out);
    return (sel_w >= SEL_W_MIN) && (sel_w <= SEL_W_MAX) &&
           (num_out >= 1) && (num_out <= (1 << sel_w));
  endfunction

endpackage

// Place inside a module body after its parameters are declared.
`define DECODER_PKG_CHECK(SEL_W_, NUM_OUT_) \
  if (!decoder_pkg::onehot_width_ok(SEL_W_, NUM_OUT_)) begin : g_bad_params \
    $error("decoder: illegal SEL_W/NUM_OUT combination"); \
  end

`endif

// File: rtl/dec_onehot.sv
// dec_onehot: combinational binary-to-one-hot decoder with enable and
// out-of-range flag. y has at most one bit set. err is set only when the
// decoder is enabled and sel has no matching output.

module dec_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] y,
  output logic               err
);

  `DECODER_PKG_CHECK(SEL_W, NUM_OUT)

  // Match sel against each implemented output index; no hit while enabled means out of range.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value held (no latch).
    y   = '0;
    err = 1'b0;
    if (en) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (sel == SEL_W'(i)) y[i] = 1'b1;
      end
      err = ~(|y);
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered one-hot decoder with a valid/ready handshake.
// The select is decoded on the input side. The {err, y} word then passes
// through a 2-entry skid buffer (main + skid), so throughput stays at one word
// per cycle while in_ready comes straight from a flop.
// Optional feature, enabled by defining DECODER_PIPE_ACC_EN: an
// OR-accumulator of handshaken words, using the acc_clr and acc_y ports.

module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_y,
  output logic               out_err
`ifdef DECODER_PIPE_ACC_EN
  ,
  input  logic               acc_clr,
  output logic [NUM_OUT-1:0] acc_y
`endif
);

  `DECODER_PKG_CHECK(SEL_W, NUM_OUT)

  localparam int W = NUM_OUT + 1;  // {err, y}

  logic [NUM_OUT-1:0] dec_y;
  logic               dec_err;
  logic [W-1:0]       new_word;

  logic               main_valid;
  logic [W-1:0]       main_word;
  logic               skid_valid;
  logic [W-1:0]       skid_word;

  logic               accept;
  logic               out_hs;

  dec_onehot #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) u_dec (
    .sel(in_sel),
    .en (in_en),
    .y  (dec_y),
    .err(dec_err)
  );

  assign new_word  = {dec_err, dec_y};
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign out_hs    = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_y     = main_word[NUM_OUT-1:0];
  assign out_err   = main_word[NUM_OUT];

  // Skid buffer. Main refills whenever it is empty or being consumed, taking
  // the skid word first to keep FIFO order. A stalled main diverts the new
  // word into skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well, because out_y/out_err must read zero during reset.
      main_valid <= 1'b0;
      main_word  <= '0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so each register reads its pre-edge neighbours.
      if (out_hs || !main_valid) begin
        if (skid_valid) begin
          // Skid full implies in_ready=0, so no accept can collide here.
          main_word  <= skid_word;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_word  <= new_word;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_word  <= new_word;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef DECODER_PIPE_ACC_EN
  // OR-accumulate every handshaken word. A clear keeps only the word
  // handshaken in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_y <= '0;
    end else if (acc_clr) begin
      acc_y <= out_hs ? out_y : '0;
    end else if (out_hs) begin
      acc_y <= acc_y | out_y;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed self-checking bench for decoder_pipe with
// SEL_W=3 and NUM_OUT=6. The accumulator scenario is included when
// DECODER_PIPE_ACC_EN is defined.
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, so each check sees the result of the preceding edge.

module tb_decoder_pipe;

  localparam int SEL_W   = 3;
  localparam int NUM_OUT = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               in_en;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_y;
  logic               out_err;
`ifdef DECODER_PIPE_ACC_EN
  logic               acc_clr;
  logic [NUM_OUT-1:0] acc_y;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_pipe #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_en    (in_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_err  (out_err)
`ifdef DECODER_PIPE_ACC_EN
    ,
    .acc_clr  (acc_clr),
    .acc_y    (acc_y)
`endif
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_en     = 1'b0;
    out_ready = 1'b1;
`ifdef DECODER_PIPE_ACC_EN
    acc_clr   = 1'b0;
`endif
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_y !== 6'b000000) begin bad++; $display("FAIL reset_y: got %b want 000000", out_y); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", out_err); end
`ifdef DECODER_PIPE_ACC_EN
    total++; if (acc_y !== 6'b000000) begin bad++; $display("FAIL reset_acc: got %b want 000000", acc_y); end
`endif
    #3 rst_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    in_sel = 3'd3; in_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    total++; if (out_y !== 6'b001000) begin bad++; $display("FAIL single_y: got %b want 001000", out_y); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", out_err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_range_enable();
    in_sel = 3'd7; in_en = 1'b1; in_valid = 1'b1;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL range_valid: got %b want 1", out_valid); end
    total++; if (out_y !== 6'b000000) begin bad++; $display("FAIL range_y: got %b want 000000", out_y); end
    total++; if (out_err !== 1'b1) begin bad++; $display("FAIL range_err: got %b want 1", out_err); end
    in_sel = 3'd5; in_en = 1'b0;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dis_valid: got %b want 1", out_valid); end
    total++; if (out_y !== 6'b000000) begin bad++; $display("FAIL dis_y: got %b want 000000", out_y); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL dis_err: got %b want 0", out_err); end
    in_sel = 3'd6; in_en = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_err !== 1'b1 || out_y !== 6'b000000) begin
      bad++; $display("FAIL range6: got err=%b y=%b want err=1 y=000000", out_err, out_y);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_y [6] = '{6'b000001, 6'b000010, 6'b000100,
                              6'b001000, 6'b010000, 6'b100000};
    in_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_sel = 3'(i); in_valid = 1'b1;
      step();
      total++; if (out_valid !== 1'b1 || out_y !== exp_y[i] || out_err !== 1'b0) begin
        bad++; $display("FAIL stream_%0d: got v=%b y=%b e=%b want v=1 y=%b e=0",
                        i, out_valid, out_y, out_err, exp_y[i]);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    in_en = 1'b1; out_ready = 1'b0;
    in_sel = 3'd1; in_valid = 1'b1;
    step();
    total++; if (out_y !== 6'b000010 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_first: got y=%b rdy=%b want y=000010 rdy=1", out_y, in_ready);
    end
    in_sel = 3'd2;
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    total++; if (out_y !== 6'b000010 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold: got v=%b y=%b want v=1 y=000010", out_valid, out_y);
    end
    step();
    total++; if (out_y !== 6'b000010 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_stall: got y=%b rdy=%b want y=000010 rdy=0", out_y, in_ready);
    end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_y !== 6'b000100) begin
      bad++; $display("FAIL bp_second: got v=%b y=%b want v=1 y=000100", out_valid, out_y);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    in_en = 1'b1; out_ready = 1'b0;
    in_sel = 3'd0; in_valid = 1'b1;
    step();
    in_sel = 3'd4;
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_full: got %b want 0", in_ready); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_y !== 6'b000000 || out_err !== 1'b0) begin
      bad++; $display("FAIL rm_async: got v=%b y=%b e=%b want v=0 y=000000 e=0", out_valid, out_y, out_err);
    end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_stale: got %b want 0", out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_stale2: got %b want 0", out_valid); end
  endtask

`ifdef DECODER_PIPE_ACC_EN
  task automatic test_accumulate();
    in_en = 1'b1; out_ready = 1'b1; acc_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_sel = 3'(2 * i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    total++; if (acc_y !== 6'b010101) begin bad++; $display("FAIL acc_or: got %b want 010101", acc_y); end
    in_sel = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    total++; if (acc_y !== 6'b000010) begin bad++; $display("FAIL acc_clr_hs: got %b want 000010", acc_y); end
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    total++; if (acc_y !== 6'b000000) begin bad++; $display("FAIL acc_clr_only: got %b want 000000", acc_y); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_range_enable();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef DECODER_PIPE_ACC_EN
    test_accumulate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Parametrised, registered binary-to-one-hot decoder for the ALU operation/register-select path.
- Generalises the fixed 2-to-4 and 3-to-8 gate decoders to SEL_W select bits, NUM_OUT outputs, a decode enable and out-of-range detection.
- Adds a valid/ready handshake through a 2-entry skid buffer, giving full throughput with a registered in_ready.
- Sits between the instruction field extractor and the ALU unit-select / register-file write-enable logic.

Parameters:
- SEL_W, 3, select width in bits; legal range 1..6.
- NUM_OUT, 8, number of one-hot outputs; 1 <= NUM_OUT <= 2**SEL_W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block can accept a transaction.
- in_sel  input  SEL_W  binary select.
- in_en  input  1  decode enable; 0 produces an all-zero word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- out_y  output  NUM_OUT  one-hot (or all-zero) decoded word.
- out_err  output  1  in_sel was >= NUM_OUT while in_en=1.
- acc_clr  input  1  synchronous accumulator clear (used only with DECODER_PIPE_ACC_EN).
- acc_y  output  NUM_OUT  OR-accumulated outputs (present only with DECODER_PIPE_ACC_EN).

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_y=0, out_err=0, skid empty, acc_y=0. in_ready=1 from the first cycle after reset release.
- Decode function: y[i]=1 iff in_en=1, in_sel==i and i<NUM_OUT.
  - in_en=0: y=0, err=0; still a transaction.
  - in_en=1 and in_sel>=NUM_OUT: y=0, err=1.
  - y never has more than one bit set.
- Accept: on in_valid && in_ready. Decode happens on the input side; registered result y/err travel together.
- Latency: 1 cycle from accept to out_valid when the output stage is empty or draining.
- Storage: two registers, main (drives outputs) and skid. in_ready = !skid_full, taken directly from a flop.
  - Accept, main empty or out_ready=1: word loads main.
  - Accept, main full and out_ready=0: word loads skid; in_ready=0 next cycle.
  - out handshake with skid full: skid moves to main; skid empties; in_ready=1 next cycle.
- Simultaneous accept and out handshake, skid empty: main reloads with the new word. No bubble; sustained 1 word/cycle.
- Order is strictly FIFO; no word is dropped or duplicated.
- Output stability: out_y/out_err hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation: both entries discarded; outputs return to reset values asynchronously.

Optional Feature:
- Macro: DECODER_PIPE_ACC_EN.
- Defined:
  - acc_clr and acc_y ports exist.
  - On each out handshake, acc_y <= acc_y | out_y.
  - acc_clr=1 alone: acc_y <= 0.
  - acc_clr=1 with a handshake in the same cycle: acc_y <= out_y, so clear drops history but keeps the current word.
  - acc_y=0 after reset.
- Undefined: acc_clr and acc_y ports and the accumulator register are absent; all other behaviour is identical.

Decomposition:
- Shared package/header decoder_pkg:
  - constant function for the one-hot width check;
  - SEL_W legal-range constants (min 1, max 6);
  - parameter assertion macro rejecting NUM_OUT > 2**SEL_W at elaboration.
- Sub-module dec_onehot: purely combinational, parameterised SEL_W/NUM_OUT, producing y and err. It is instantiated once, on the input side.
- The skid buffer stays inline in decoder_pipe.

Test Plan (SEL_W=3, NUM_OUT=6):
- Reset, then in_sel=3, in_en=1, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_y=6'b001000, out_err=0; in_ready stays 1.
- in_sel=7, in_en=1 -> out_y=6'b000000, out_err=1. Then in_sel=5, in_en=0 -> out_y=0, out_err=0.
- Stream sel 0..5 back-to-back with out_ready=1 -> out_valid high for 6 consecutive cycles, outputs 000001..100000 in order, no bubbles.
- out_ready=0, feed sel=1 then sel=2 -> in_ready=0 after the second accept, out_y holds 000010. Raise out_ready -> 000010 then 000100; in_ready returns to 1.
- Assert rst_n=0 while both entries are full -> out_valid=0, out_y=0 immediately. After release, in_ready=1 and no stale word appears.
- With DECODER_PIPE_ACC_EN: handshakes sel 0, 2, 4 -> acc_y=010101. Then acc_clr with a handshake of sel=1 in the same cycle -> acc_y=000010.
